int2fp_pipe: RTL and testbench

- Pipelined signed/unsigned integer to FloPoCo floating-point converter with valid/ready handshakes on both sides; the inverse of our float-to-integer conversion path.
- Native RTL, no generated core.
- Output uses the FloPoCo internal format: {exc[1:0], sign, exponent, mantissa}, exc 00=zero, 01=normal, 10=inf, 11=NaN.
- Sits between integer ALU results and FloPoCo arithmetic units in the FP datapath.

---
 rtl/int2fp_pipe.sv | 179 +++++++++++++++++
 tb/tb_int2fp_pipe.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int2fp_pipe.sv
// int2fp_pipe: pipelined signed/unsigned integer to FloPoCo float converter.
// Abs value, normalize, then round/pack, with valid/ready on both sides.
module int2fp_pipe #(
  parameter int DataWidth = 32,
  parameter int Latency   = 2,
  parameter bit Signed    = 1'b1,
  parameter int TagWidth  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DataWidth-1:0] int_i,
  input  logic [TagWidth-1:0]  tag_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DataWidth+1:0] fp_o,
  output logic                 inexact_o,
  output logic [TagWidth-1:0]  tag_o,
  output logic                 busy_o
);

  localparam int DW   = DataWidth;
  localparam int EW   = (DW == 16) ? 5 : 8;
  localparam int MW   = (DW == 16) ? 10 : 23;
  localparam int BIAS = (DW == 16) ? 15 : 127;
  localparam int PW   = $clog2(DW);
  localparam int GB   = DW - 2 - MW;

  if (DataWidth != 16 && DataWidth != 32) begin : g_bad_dw
    $error("int2fp_pipe: DataWidth must be 16 or 32");
  end
  if (Latency < 1 || Latency > 3) begin : g_bad_lat
    $error("int2fp_pipe: Latency must be 1..3");
  end
  if (TagWidth < 1) begin : g_bad_tag
    $error("int2fp_pipe: TagWidth must be at least 1");
  end

  typedef struct packed {
    logic                sign;
    logic [DW-1:0]       mag;
    logic [TagWidth-1:0] tag;
  } a_t;

  typedef struct packed {
    logic                sign;
    logic [PW-1:0]       p;
    logic [DW-1:0]       norm;
    logic [TagWidth-1:0] tag;
  } b_t;

  typedef struct packed {
    logic [DW+1:0]       fp;
    logic                inexact;
    logic [TagWidth-1:0] tag;
  } c_t;

  logic ld1, ld2, ld3;
  logic v1, v2;
  logic s1_v, s2_v;
  a_t   a_d, s1;
  b_t   b_d, s2;
  c_t   c_d, r3_q;
  logic v3_q;

  // Stage A: sign split; -2^(DW-1) stays representable as unsigned.
  logic a_neg;
  assign a_neg = Signed && int_i[DW-1];

  always_comb begin
    a_d.sign = a_neg;
    a_d.mag  = a_neg ? -int_i : int_i;
    a_d.tag  = tag_i;
  end

  if (Latency >= 3) begin : g_r1
    a_t   r1_q;
    logic v1_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        v1_q <= 1'b0;
        r1_q <= '0;
      end else if (ld1) begin
        v1_q <= in_valid_i;
        if (in_valid_i) r1_q <= a_d;
      end
    end
    assign ld1  = !v1_q || ld2;
    assign s1   = r1_q;
    assign s1_v = v1_q;
    assign v1   = v1_q;
  end else begin : g_n1
    assign ld1  = ld2;
    assign s1   = a_d;
    assign s1_v = in_valid_i;
    assign v1   = 1'b0;
  end

  // Stage B: position of the top set bit, then shift it to the MSB.
  always_comb begin
    logic [PW-1:0] pos;
    pos = '0;
    for (int i = 0; i < DW; i++) begin
      if (s1.mag[i]) pos = PW'(i);
    end
    b_d.sign = s1.sign;
    b_d.p    = pos;
    b_d.norm = s1.mag << (PW'(DW - 1) - pos);
    b_d.tag  = s1.tag;
  end

  if (Latency >= 2) begin : g_r2
    b_t   r2_q;
    logic v2_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        v2_q <= 1'b0;
        r2_q <= '0;
      end else if (ld2) begin
        v2_q <= s1_v;
        if (s1_v) r2_q <= b_d;
      end
    end
    assign ld2  = !v2_q || ld3;
    assign s2   = r2_q;
    assign s2_v = v2_q;
    assign v2   = v2_q;
  end else begin : g_n2
    assign ld2  = ld3;
    assign s2   = b_d;
    assign s2_v = s1_v;
    assign v2   = 1'b0;
  end

  // Stage C: round to nearest even; the MSB of norm doubles as nonzero flag.
  logic [MW-1:0] mant;
  logic [MW:0]   mant_r;
  logic [EW-1:0] expo;
  logic          lsb, guard, sticky, rup, nz;

  always_comb begin
    nz     = s2.norm[DW-1];
    mant   = s2.norm[DW-2 -: MW];
    lsb    = s2.norm[DW-1-MW];
    guard  = s2.norm[GB];
    sticky = |s2.norm[GB-1:0];
    rup    = guard & (sticky | lsb);
    mant_r = {1'b0, mant} + {{MW{1'b0}}, rup};
    expo   = EW'(s2.p) + EW'(BIAS) + {{(EW-1){1'b0}}, mant_r[MW]};
    c_d.fp      = '0;
    c_d.inexact = 1'b0;
    c_d.tag     = s2.tag;
    if (nz) begin
      c_d.fp      = {2'b01, s2.sign, expo, mant_r[MW-1:0]};
      c_d.inexact = guard | sticky;
    end
  end

  assign ld3 = !v3_q || out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v3_q <= 1'b0;
      r3_q <= '0;
    end else if (ld3) begin
      v3_q <= s2_v;
      if (s2_v) r3_q <= c_d;
    end
  end

  assign in_ready_o  = ld1;
  assign out_valid_o = v3_q;
  assign fp_o        = r3_q.fp;
  assign inexact_o   = r3_q.inexact;
  assign tag_o       = r3_q.tag;
  assign busy_o      = v1 | v2 | v3_q;

endmodule

// File: tb/tb_int2fp_pipe.sv
// tb_int2fp_pipe: five converter configurations checked every cycle
// against an arithmetic reference model and hand-computed literals.
module tb_int2fp_pipe;

  localparam int N = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        iv[N], ir[N], ov[N], ordy[N], ix[N], bz[N];
  logic [31:0] ii[N];
  logic [3:0]  ti[N], to[N];
  logic [33:0] fo[N];
  logic [17:0] fo16;

  assign fo[4] = {16'd0, fo16};

  int dwk[N]  = '{32, 32, 32, 32, 16};
  int latk[N] = '{2, 1, 3, 2, 2};
  bit sgk[N]  = '{1, 1, 1, 0, 1};

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit bp_on = 0;

  always #5 clk = ~clk;

  int2fp_pipe #(.DataWidth(32), .Latency(2), .Signed(1'b1), .TagWidth(4)) u_d0 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(iv[0]), .in_ready_o(ir[0]),
    .int_i(ii[0]), .tag_i(ti[0]), .out_valid_o(ov[0]), .out_ready_i(ordy[0]),
    .fp_o(fo[0]), .inexact_o(ix[0]), .tag_o(to[0]), .busy_o(bz[0]));

  int2fp_pipe #(.DataWidth(32), .Latency(1), .Signed(1'b1), .TagWidth(4)) u_d1 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(iv[1]), .in_ready_o(ir[1]),
    .int_i(ii[1]), .tag_i(ti[1]), .out_valid_o(ov[1]), .out_ready_i(ordy[1]),
    .fp_o(fo[1]), .inexact_o(ix[1]), .tag_o(to[1]), .busy_o(bz[1]));

  int2fp_pipe #(.DataWidth(32), .Latency(3), .Signed(1'b1), .TagWidth(4)) u_d2 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(iv[2]), .in_ready_o(ir[2]),
    .int_i(ii[2]), .tag_i(ti[2]), .out_valid_o(ov[2]), .out_ready_i(ordy[2]),
    .fp_o(fo[2]), .inexact_o(ix[2]), .tag_o(to[2]), .busy_o(bz[2]));

  int2fp_pipe #(.DataWidth(32), .Latency(2), .Signed(1'b0), .TagWidth(4)) u_d3 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(iv[3]), .in_ready_o(ir[3]),
    .int_i(ii[3]), .tag_i(ti[3]), .out_valid_o(ov[3]), .out_ready_i(ordy[3]),
    .fp_o(fo[3]), .inexact_o(ix[3]), .tag_o(to[3]), .busy_o(bz[3]));

  int2fp_pipe #(.DataWidth(16), .Latency(2), .Signed(1'b1), .TagWidth(4)) u_d4 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(iv[4]), .in_ready_o(ir[4]),
    .int_i(ii[4][15:0]), .tag_i(ti[4]), .out_valid_o(ov[4]), .out_ready_i(ordy[4]),
    .fp_o(fo16), .inexact_o(ix[4]), .tag_o(to[4]), .busy_o(bz[4]));

  typedef struct {
    logic [34:0] exp;
    logic [34:0] lit;
    bit          has;
    logic [3:0]  tag;
    int          acc;
  } item_t;

  typedef struct {
    bit          has;
    logic [34:0] v;
  } lit_t;

  item_t sbq[N][$];
  lit_t  litq[N][$];
  bit          pstall[N];
  logic [33:0] pfo[N];
  logic        pix[N];
  logic [3:0]  pto[N];

  task automatic chk(string nm, int k, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got=%h want=%h", nm, k, $time, act, exp);
    end
  endtask

  // {inexact, fp} from plain integer arithmetic on the input value.
  function automatic logic [34:0] model(int dw, bit sgn, logic [31:0] x);
    int mw, bias, p, sh;
    longint v, q, rem, half, e;
    bit s, inx;
    logic [33:0] fp;
    mw   = (dw == 16) ? 10 : 23;
    bias = (dw == 16) ? 15 : 127;
    v    = (dw == 16) ? longint'(x[15:0]) : longint'(x);
    s    = sgn && x[dw-1];
    if (s) v = (64'sd1 <<< dw) - v;
    if (v == 0) return 35'd0;
    p = 0;
    while ((v >> (p + 1)) != 0) p++;
    inx = 0;
    if (p <= mw) begin
      q = v << (mw - p);
    end else begin
      sh   = p - mw;
      q    = v >> sh;
      rem  = v - (q << sh);
      half = 64'sd1 <<< (sh - 1);
      inx  = (rem != 0);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (64'sd1 <<< (mw + 1))) begin
        q = q >> 1;
        p++;
      end
    end
    e  = p + bias;
    fp = (dw == 16) ? {16'd0, 2'b01, s, e[4:0], q[9:0]}
                    : {2'b01, s, e[7:0], q[22:0]};
    return {inx, fp};
  endfunction

  function automatic logic [34:0] f32(bit inx, bit s, int e, int m);
    return {inx, 2'b01, s, e[7:0], m[22:0]};
  endfunction

  function automatic logic [34:0] f16(bit inx, bit s, int e, int m);
    return {inx, 16'd0, 2'b01, s, e[4:0], m[9:0]};
  endfunction

  task automatic mon(int k);
    item_t it;
    lit_t  lt;
    bit    eov;
    int    sz;
    sz = sbq[k].size();
    chk("in_ready", k, ir[k], (sz < latk[k]) || ordy[k]);
    chk("busy", k, bz[k], sz != 0);
    eov = (sz != 0) && (cyc >= sbq[k][0].acc + latk[k]);
    chk("out_valid", k, ov[k], eov);
    if (pstall[k])
      chk("stall_hold", k, {ix[k], to[k], fo[k]}, {pix[k], pto[k], pfo[k]});
    if (ov[k] && ordy[k]) begin
      if (sz == 0) begin
        chk("spurious", k, ov[k], 0);
      end else begin
        it = sbq[k].pop_front();
        chk("result", k, {ix[k], fo[k]}, it.exp);
        chk("tag", k, to[k], it.tag);
        if (it.has) chk("literal", k, {ix[k], fo[k]}, it.lit);
      end
    end
    if (iv[k] && ir[k]) begin
      if (litq[k].size() == 0) lt = '{has: 1'b0, v: '0};
      else lt = litq[k].pop_front();
      it.exp = model(dwk[k], sgk[k], ii[k]);
      it.lit = lt.v;
      it.has = lt.has;
      it.tag = ti[k];
      it.acc = cyc;
      sbq[k].push_back(it);
    end
    pstall[k] = ov[k] && !ordy[k];
    pfo[k] = fo[k];
    pix[k] = ix[k];
    pto[k] = to[k];
  endtask

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < N; k++) begin
      if (!rst_n) begin
        sbq[k].delete();
        litq[k].delete();
        pstall[k] = 1'b0;
      end else begin
        mon(k);
      end
    end
  end

  int ph = 0;
  initial forever begin
    @(posedge clk);
    #1;
    if (bp_on) begin
      ph = (ph + 1) % 4;
      for (int k = 0; k < 3; k++) ordy[k] = (ph == 0) || (ph == 3);
    end
  end

  task automatic send(int k, logic [31:0] x, logic [3:0] t, bit has, logic [34:0] lit);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    litq[k].push_back('{has: has, v: lit});
    iv[k] = 1'b1;
    ii[k] = x;
    ti[k] = t;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = ir[k];
      @(posedge clk);
      #1;
      n++;
    end
    iv[k] = 1'b0;
    if (!acc) begin
      chk("accept_timeout", k, 0, 1);
      litq[k].delete();
    end
  endtask

  function automatic int pending();
    int s;
    s = 0;
    for (int k = 0; k < N; k++) s += sbq[k].size();
    return s;
  endfunction

  task automatic drain(int maxc);
    int n;
    n = 0;
    while (n < maxc && pending() != 0) begin
      @(posedge clk);
      #1;
      n++;
    end
    for (int k = 0; k < N; k++) chk("drain", k, sbq[k].size(), 0);
  endtask

  task automatic chk_reset_outs(string nm);
    for (int k = 0; k < N; k++) begin
      chk(nm, k, {ov[k], bz[k], ix[k], to[k], fo[k]}, '0);
    end
  endtask

  function automatic logic [31:0] rnd();
    logic [31:0] x;
    x = $urandom >> $urandom_range(0, 31);
    if ($urandom_range(0, 1) == 1) x = -x;
    return x;
  endfunction

  initial begin
    for (int k = 0; k < N; k++) begin
      iv[k] = 1'b0;
      ii[k] = '0;
      ti[k] = '0;
      ordy[k] = 1'b1;
      pstall[k] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk_reset_outs("reset_state");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < N; k++) chk("ready_after_reset", k, ir[k], 1);
    @(posedge clk);
    #1;

    chk("model_pin_tie_up", 0, model(32, 1, 32'd16777219), f32(1, 0, 151, 2));
    chk("model_pin_half", 4, model(16, 1, 32'd32767), f16(1, 0, 30, 0));
    chk("model_pin_uns", 3, model(32, 0, 32'hFFFFFFFF), f32(1, 0, 159, 0));

    send(0, 32'd1,         4'd0, 1, f32(0, 0, 127, 0));
    send(0, 32'hFFFFFFFF,  4'd1, 1, f32(0, 1, 127, 0));
    send(0, 32'd0,         4'd2, 1, 35'd0);
    send(0, 32'd16777217,  4'd3, 1, f32(1, 0, 151, 0));
    send(0, 32'd16777219,  4'd4, 1, f32(1, 0, 151, 2));
    send(0, 32'd16777218,  4'd5, 1, f32(0, 0, 151, 1));
    send(0, 32'h80000000,  4'd6, 1, f32(0, 1, 158, 0));
    send(0, 32'h7FFFFFFF,  4'd7, 1, f32(1, 0, 158, 0));
    send(3, 32'hFFFFFFFF,  4'd1, 1, f32(1, 0, 159, 0));
    send(3, 32'h80000000,  4'd2, 1, f32(0, 0, 158, 0));
    send(3, 32'd5,         4'd3, 1, f32(0, 0, 129, 32'h200000));
    send(4, 32'd2049,      4'd4, 1, f16(1, 0, 26, 0));
    send(4, 32'd32767,     4'd5, 1, f16(1, 0, 30, 0));
    send(4, 32'h00008000,  4'd6, 1, f16(0, 1, 30, 0));
    send(4, 32'd3,         4'd7, 1, f16(0, 0, 16, 32'h200));
    drain(50);

    bp_on = 1'b1;
    fork
      for (int i = 0; i < 8; i++) send(0, rnd(), 4'(i), 0, '0);
      for (int i = 0; i < 8; i++) send(1, rnd(), 4'(i), 0, '0);
      for (int i = 0; i < 8; i++) send(2, rnd(), 4'(i), 0, '0);
    join
    drain(100);
    bp_on = 1'b0;
    for (int k = 0; k < N; k++) ordy[k] = 1'b1;
    @(posedge clk);
    #1;

    fork
      for (int i = 0; i < 100; i++) send(0, rnd(), 4'(i), 0, '0);
      for (int i = 0; i < 100; i++) send(1, rnd(), 4'(i), 0, '0);
      for (int i = 0; i < 100; i++) send(2, rnd(), 4'(i), 0, '0);
      for (int i = 0; i < 100; i++) send(3, rnd(), 4'(i), 0, '0);
      for (int i = 0; i < 100; i++) send(4, rnd(), 4'(i), 0, '0);
    join
    drain(50);

    ordy[2] = 1'b0;
    send(2, 32'd100, 4'd1, 0, '0);
    send(2, 32'd200, 4'd2, 0, '0);
    send(2, 32'd300, 4'd3, 0, '0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("reset_midflight");
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    ordy[2] = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    drain(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
